// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared state encoding and one-hot helper for prio_enc_arb
package prio_enc_pkg;
  localparam int MAX_N = 256;
  localparam int MAX_W = 8;
  typedef enum logic {IDLE, HOLD} prio_enc_state_t;
  function automatic logic [MAX_N-1:0] onehot_of(input logic [MAX_W-1:0] idx);
    return MAX_N'(1) << idx;
  endfunction
endpackage

// File: rtl/prio_enc_find.sv
// prio_enc_find: find-first-set scanning downward from start, wrapping N-1 after 0
module prio_enc_find #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);
  always_comb begin
    int p;
    found = 1'b0;
    idx = '0;
    p = 0;
    for (int j = 0; j < N; j++) begin
      p = (int'(start) >= j) ? int'(start) - j : int'(start) + N - j;
      if (!found && req[p]) begin
        found = 1'b1;
        idx = W'(p);
      end
    end
  end
endmodule

// File: rtl/prio_enc_arb.sv
// prio_enc_arb: registered priority arbiter with valid/ready grant port
// Define PRIO_ENC_ARB_RR_EN for round-robin fairness; default is fixed highest-index priority.
module prio_enc_arb
  import prio_enc_pkg::*;
#(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_gnt
);
  prio_enc_state_t state_q;
  logic [W-1:0] idx_q, f_idx, start;
  logic [N-1:0] gnt_q;
  logic found, load;
`ifdef PRIO_ENC_ARB_RR_EN
  logic [W-1:0] ptr_q, ptr_d;
  assign start = ptr_q;
  assign ptr_d = (f_idx == '0) ? W'(N-1) : f_idx - W'(1);
  always_ff @(posedge clk)
    if (rst) ptr_q <= W'(N-1);
    else if (load) ptr_q <= ptr_d;
`else
  assign start = W'(N-1);
`endif
  prio_enc_find #(.N(N)) u_find (.req(req), .start(start), .found(found), .idx(f_idx));
  assign load = found && (state_q == IDLE || out_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      gnt_q <= '0;
    end else if (load) begin
      state_q <= HOLD;
      idx_q <= f_idx;
      gnt_q <= N'(onehot_of(MAX_W'(f_idx)));
    end else if (state_q == HOLD && out_ready) begin
      state_q <= IDLE;
      gnt_q <= '0;
    end
  end
  assign out_valid = (state_q == HOLD);
  assign out_idx = idx_q;
  assign out_gnt = gnt_q;
endmodule

// File: tb/tb_prio_enc_arb.sv
// tb_prio_enc_arb: directed checks of reset, pick, stall, back-to-back, drain and wrap
module tb_prio_enc_arb;
  logic clk = 1'b0, rst, out_ready, out_valid;
  logic [7:0] req, out_gnt;
  logic [2:0] out_idx;
  int n_tests = 0, n_fail = 0;
  prio_enc_arb #(.N(8)) dut (.clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
                             .out_valid(out_valid), .out_idx(out_idx), .out_gnt(out_gnt));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic grant(input string tag, input int idx);
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_idx"}, 32'(out_idx), 32'(idx));
    check({tag, "_gnt"}, 32'(out_gnt), 32'(1) << idx);
  endtask
  task automatic idle(input string tag, input int idx);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_idx"}, 32'(out_idx), 32'(idx));
    check({tag, "_gnt"}, 32'(out_gnt), 0);
  endtask
`ifdef PRIO_ENC_ARB_RR_EN
  int b2b[3] = '{0, 7, 0};
  int wrap[3] = '{7, 6, 5};
  int after_rst = 0;
`else
  int b2b[3] = '{7, 7, 7};
  int wrap[3] = '{7, 7, 7};
  int after_rst = 7;
`endif
  initial begin
    rst = 1'b1; req = 8'hFF; out_ready = 1'b0;
    step(); idle("rst0", 0);
    step(); idle("rst1", 0);
    rst = 1'b0;
    step(); grant("first", 7);
    out_ready = 1'b1; req = 8'b0010_0110;
    step(); grant("pick", 5);
    out_ready = 1'b0; req = 8'h80;
    for (int i = 0; i < 4; i++) begin
      step(); grant($sformatf("stall%0d", i), 5);
    end
    out_ready = 1'b1;
    step(); grant("release", 7);
    req = 8'h81;
    for (int i = 0; i < 3; i++) begin
      step(); grant($sformatf("b2b%0d", i), b2b[i]);
    end
    req = 8'h00;
    step(); idle("drain", b2b[2]);
    out_ready = 1'b0;
    step(); idle("idle_hold", b2b[2]);
    req = 8'h04;
    step(); grant("reload", 2);
    out_ready = 1'b1; req = 8'h01;
    step(); grant("wrap_lo", 0);
    req = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step(); grant($sformatf("wrap%0d", i), wrap[i]);
    end
    out_ready = 1'b0; rst = 1'b1;
    step(); idle("mid_rst", 0);
    rst = 1'b0; req = 8'h81;
    step(); grant("post_rst", 7);
    out_ready = 1'b1;
    step(); grant("post_rst_b2b", after_rst);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
